// File: rtl/dense_l3_fetch_seq.sv
// dense_l3_fetch_seq: address sequencer for the dense layer-3 weight ROM.
//
// Eight dual-port ROM banks share one base address (port A reads addr_base,
// port B reads addr_base+1). Each step therefore yields 16 x 32-bit words.
// The sequencer walks num_steps steps from base_addr, two addresses per step.
// It issues one address per cycle and tracks the ROM read latency with a
// valid/tag pipeline. It presents a valid/ready stream, tagged with the step
// index, to the MAC array. When the consumer stalls, it replays from the
// oldest unaccepted step.
//
// Optional feature (macro DENSE_L3_FETCH_SEQ_PERF_EN): adds the stall_cnt
// output. stall_cnt counts stall cycles plus the replay cycles that follow
// each stall.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch pulse, sampled only when idle
//   base_addr         address of step 0 (latched on start)
//   num_steps         number of steps to fetch (latched on start)
//   mem_addr          ROM addr_base (registered)
//   wt_valid, wt_idx  ROM outputs hold step wt_idx
//   wt_ready          MAC array accepts the presented step
//   busy              sequence in progress (RUN or FINISH)
//   done              one-cycle pulse once the last step is accepted
//   stall_cnt         (PERF_EN only) saturating stall/replay cycle count
module dense_l3_fetch_seq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned STEP_W = 7,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [STEP_W-1:0] num_steps,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wt_valid,
  output logic [STEP_W-1:0] wt_idx,
  input  logic              wt_ready,
  output logic              busy,
  output logic              done
`ifdef DENSE_L3_FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // Stage 0 is aligned with mem_addr. The last stage is aligned with the
  // ROM output, RD_LAT cycles later.
  localparam int unsigned DEPTH = RD_LAT + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;
  logic [STEP_W-1:0] issue_ptr_q, issue_ptr_d;
  logic [STEP_W-1:0] acc_ptr_q, acc_ptr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DEPTH-1:0]  pv_q, pv_d;
  logic [STEP_W-1:0] ptag_q [DEPTH];
  logic [STEP_W-1:0] ptag_d [DEPTH];
  logic              busy_d, done_d;

  logic              accept_c, stall_c;
  logic [STEP_W-1:0] issue_src_c;
  logic [STEP_W-1:0] acc_inc_c;

  assign wt_valid = pv_q[DEPTH-1];
  assign wt_idx   = ptag_q[DEPTH-1];

  assign accept_c  = (state_q == S_RUN) && wt_valid && wt_ready;
  assign stall_c   = (state_q == S_RUN) && wt_valid && !wt_ready;
  assign acc_inc_c = acc_ptr_q + STEP_W'(1);
  // A stall rewinds issue to the oldest unaccepted step in the same cycle.
  assign issue_src_c = stall_c ? acc_ptr_q : issue_ptr_q;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nsteps_d    = nsteps_q;
    issue_ptr_d = issue_ptr_q;
    acc_ptr_d   = acc_ptr_q;
    mem_addr_d  = mem_addr;
    pv_d        = {pv_q[DEPTH-2:0], 1'b0};
    ptag_d[0]   = ptag_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      ptag_d[i] = ptag_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        pv_d = '0;
        if (start) begin
          base_d      = base_addr;
          nsteps_d    = num_steps;
          issue_ptr_d = '0;
          acc_ptr_d   = '0;
          state_d     = (num_steps == '0) ? S_FINISH : S_RUN;
        end
      end

      S_RUN: begin
        if (stall_c) begin
          pv_d = '0;
        end
        if (issue_src_c < nsteps_q) begin
          // Two addresses per step; the sum wraps modulo 2^ADDR_W.
          mem_addr_d  = base_q + ADDR_W'({issue_src_c, 1'b0});
          issue_ptr_d = issue_src_c + STEP_W'(1);
          pv_d[0]     = 1'b1;
          ptag_d[0]   = issue_src_c;
        end else begin
          issue_ptr_d = issue_src_c;
        end
        if (accept_c) begin
          acc_ptr_d = acc_inc_c;
          if (acc_inc_c == nsteps_q) begin
            state_d = S_FINISH;
            pv_d    = '0;
          end
        end
      end

      S_FINISH: begin
        pv_d    = '0;
        state_d = S_IDLE;
      end

      default: begin
        pv_d    = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      nsteps_q    <= '0;
      issue_ptr_q <= '0;
      acc_ptr_q   <= '0;
      mem_addr    <= '0;
      pv_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ptag_q[i] <= '0;
      end
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nsteps_q    <= nsteps_d;
      issue_ptr_q <= issue_ptr_d;
      acc_ptr_q   <= acc_ptr_d;
      mem_addr    <= mem_addr_d;
      pv_q        <= pv_d;
      for (int i = 0; i < DEPTH; i++) begin
        ptag_q[i] <= ptag_d[i];
      end
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef DENSE_L3_FETCH_SEQ_PERF_EN
  // The replay window covers the RD_LAT+1 cycles after a stall, up to the
  // cycle in which the stalled step is on the bus again.
  localparam int unsigned REP_W = $clog2(RD_LAT + 2);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [15:0]      stall_cnt_d;

  // Stall/replay cycle accounting.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    stall_cnt_d = stall_cnt;
    if ((state_q == S_IDLE) && start) begin
      rep_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if ((stall_c || (rep_cnt_q != '0)) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt + 16'd1;
      end
      if (stall_c) begin
        rep_cnt_d = REP_W'(RD_LAT + 1);
      end else if (rep_cnt_q != '0) begin
        rep_cnt_d = rep_cnt_q - REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      stall_cnt <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      stall_cnt <= stall_cnt_d;
    end
  end
`endif

endmodule
